// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: multi-cycle read-modify-write on the single-port
// CSR file, with strict-priority full-word writes from the trap unit.
module csr_access_ctrl #(
    parameter int XLEN       = 32,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  instr_req_valid,
    output logic                  instr_req_ready,
    input  logic                  instr_read_enable,
    input  logic                  instr_write_enable,
    input  logic [1:0]            instr_write_func,
    input  logic                  instr_input_select,
    input  logic [CSR_ADDR_W-1:0] instr_csr_addr,
    input  logic [XLEN-1:0]       instr_rs1_value,
    input  logic [4:0]            instr_uimm,
    input  logic                  instr_flush,
    output logic                  instr_resp_valid,
    output logic [XLEN-1:0]       instr_read_data,
    output logic                  instr_illegal,
    input  logic                  trap_req_valid,
    output logic                  trap_req_ready,
    input  logic [CSR_ADDR_W-1:0] trap_csr_addr,
    input  logic [XLEN-1:0]       trap_write_data,
    output logic                  csr_rd_en,
    output logic [CSR_ADDR_W-1:0] csr_rd_addr,
    input  logic [XLEN-1:0]       csr_rd_data,
    input  logic                  csr_rd_invalid,
    output logic                  csr_wr_en,
    output logic [CSR_ADDR_W-1:0] csr_wr_addr,
    output logic [XLEN-1:0]       csr_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        MODIFY,
        WRITE,
        TRAP_WR
    } state_t;

    localparam logic [1:0] FUNC_NONE = 2'b00;
    localparam logic [1:0] FUNC_RS   = 2'b10;
    localparam logic [1:0] FUNC_RC   = 2'b11;

    state_t                state;
    logic                  q_read;
    logic                  q_write;
    logic [1:0]            q_func;
    logic                  q_sel;
    logic [CSR_ADDR_W-1:0] q_addr;
    logic [XLEN-1:0]       q_rs1;
    logic [4:0]            q_uimm;
    logic                  q_ro;
    logic                  q_bad;
    logic [XLEN-1:0]       q_old;
    logic [XLEN-1:0]       q_tdata;

    logic [XLEN-1:0]       src;
    logic [XLEN-1:0]       new_val;
    logic                  fault;
    logic                  accept_ro;

    assign accept_ro = instr_write_enable
                     & (instr_csr_addr[CSR_ADDR_W-1 -: 2] == 2'b11);

    // Sequencer: latches requests in IDLE and walks the access states
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            q_read  <= 1'b0;
            q_write <= 1'b0;
            q_func  <= FUNC_NONE;
            q_sel   <= 1'b0;
            q_addr  <= '0;
            q_rs1   <= '0;
            q_uimm  <= '0;
            q_ro    <= 1'b0;
            q_bad   <= 1'b0;
            q_old   <= '0;
            q_tdata <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trap_req_valid) begin
                        q_addr  <= trap_csr_addr;
                        q_tdata <= trap_write_data;
                        state   <= TRAP_WR;
                    end else if (instr_req_valid && !instr_flush) begin
                        q_read  <= instr_read_enable;
                        q_write <= instr_write_enable;
                        q_func  <= instr_write_func;
                        q_sel   <= instr_input_select;
                        q_addr  <= instr_csr_addr;
                        q_rs1   <= instr_rs1_value;
                        q_uimm  <= instr_uimm;
                        q_ro    <= accept_ro;
                        q_bad   <= 1'b0;
                        q_old   <= '0;
                        state   <= instr_read_enable ? READ : WRITE;
                    end
                end
                READ: begin
                    state <= instr_flush ? IDLE : MODIFY;
                end
                MODIFY: begin
                    if (instr_flush) begin
                        state <= IDLE;
                    end else begin
                        q_old <= csr_rd_data;
                        q_bad <= csr_rd_invalid;
                        state <= WRITE;
                    end
                end
                WRITE:   state <= IDLE;
                TRAP_WR: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign src = q_sel ? {{(XLEN-5){1'b0}}, q_uimm} : q_rs1;

    // New CSR value from the old value (zero when not read) and operand
    always_comb begin
        new_val = src;
        case (q_func)
            FUNC_RS: new_val = q_old | src;
            FUNC_RC: new_val = q_old & ~src;
            default: new_val = src;
        endcase
    end

    assign fault = q_bad | q_ro;

    assign trap_req_ready  = (state == IDLE);
    assign instr_req_ready = (state == IDLE) & ~trap_req_valid & ~instr_flush;

    assign csr_rd_en   = (state == READ);
    assign csr_rd_addr = q_addr;

    assign csr_wr_en   = ((state == WRITE) & q_write & ~fault
                          & (q_func != FUNC_NONE))
                       | (state == TRAP_WR);
    assign csr_wr_addr = q_addr;
    assign csr_wr_data = (state == TRAP_WR) ? q_tdata : new_val;

    assign instr_resp_valid = (state == WRITE);
    assign instr_illegal    = (state == WRITE) & fault;
    assign instr_read_data  = ((state == WRITE) & q_read & ~fault)
                            ? q_old : '0;

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl: read-modify-write paths, read-only
// and invalid faults, trap priority, flush and reset abandonment.
module tb_csr_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        instr_req_valid = 1'b0;
    logic        instr_req_ready;
    logic        instr_read_enable = 1'b0;
    logic        instr_write_enable = 1'b0;
    logic [1:0]  instr_write_func = 2'b00;
    logic        instr_input_select = 1'b0;
    logic [11:0] instr_csr_addr = '0;
    logic [31:0] instr_rs1_value = '0;
    logic [4:0]  instr_uimm = '0;
    logic        instr_flush = 1'b0;
    logic        instr_resp_valid;
    logic [31:0] instr_read_data;
    logic        instr_illegal;
    logic        trap_req_valid = 1'b0;
    logic        trap_req_ready;
    logic [11:0] trap_csr_addr = '0;
    logic [31:0] trap_write_data = '0;
    logic        csr_rd_en;
    logic [11:0] csr_rd_addr;
    logic [31:0] csr_rd_data = '0;
    logic        csr_rd_invalid = 1'b0;
    logic        csr_wr_en;
    logic [11:0] csr_wr_addr;
    logic [31:0] csr_wr_data;

    int checks = 0;
    int errors = 0;

    csr_access_ctrl dut (
        .clk                (clk),
        .reset              (reset),
        .instr_req_valid    (instr_req_valid),
        .instr_req_ready    (instr_req_ready),
        .instr_read_enable  (instr_read_enable),
        .instr_write_enable (instr_write_enable),
        .instr_write_func   (instr_write_func),
        .instr_input_select (instr_input_select),
        .instr_csr_addr     (instr_csr_addr),
        .instr_rs1_value    (instr_rs1_value),
        .instr_uimm         (instr_uimm),
        .instr_flush        (instr_flush),
        .instr_resp_valid   (instr_resp_valid),
        .instr_read_data    (instr_read_data),
        .instr_illegal      (instr_illegal),
        .trap_req_valid     (trap_req_valid),
        .trap_req_ready     (trap_req_ready),
        .trap_csr_addr      (trap_csr_addr),
        .trap_write_data    (trap_write_data),
        .csr_rd_en          (csr_rd_en),
        .csr_rd_addr        (csr_rd_addr),
        .csr_rd_data        (csr_rd_data),
        .csr_rd_invalid     (csr_rd_invalid),
        .csr_wr_en          (csr_wr_en),
        .csr_wr_addr        (csr_wr_addr),
        .csr_wr_data        (csr_wr_data)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic re, input logic we, input logic [1:0] fn,
                       input logic sel, input logic [11:0] addr,
                       input logic [31:0] rs1, input logic [4:0] imm);
        instr_read_enable  = re;
        instr_write_enable = we;
        instr_write_func   = fn;
        instr_input_select = sel;
        instr_csr_addr     = addr;
        instr_rs1_value    = rs1;
        instr_uimm         = imm;
        instr_req_valid    = 1'b1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_resp", {31'b0, instr_resp_valid}, 32'd0);
        chk("rst_ill", {31'b0, instr_illegal}, 32'd0);
        chk("rst_rdata", instr_read_data, 32'd0);
        chk("rst_rd_en", {31'b0, csr_rd_en}, 32'd0);
        chk("rst_wr_en", {31'b0, csr_wr_en}, 32'd0);
        reset = 1'b0;
        step();
        chk("idle_ready", {31'b0, instr_req_ready}, 32'd1);
        chk("idle_tready", {31'b0, trap_req_ready}, 32'd1);

        // CSRRS 0x300, file 0x8, rs1 0x80
        csr_rd_data = 32'h0000_0008;
        req(1'b1, 1'b1, 2'b10, 1'b0, 12'h300, 32'h80, 5'd0);
        #1;
        chk("rs_ready", {31'b0, instr_req_ready}, 32'd1);
        step();
        instr_req_valid = 1'b0;
        chk("rs_c1_rd", {31'b0, csr_rd_en}, 32'd1);
        chk("rs_c1_addr", {20'b0, csr_rd_addr}, 32'h300);
        chk("rs_c1_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("rs_c1_rdy", {31'b0, instr_req_ready}, 32'd0);
        step();
        chk("rs_c2_rd", {31'b0, csr_rd_en}, 32'd0);
        chk("rs_c2_resp", {31'b0, instr_resp_valid}, 32'd0);
        step();
        chk("rs_c3_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("rs_c3_waddr", {20'b0, csr_wr_addr}, 32'h300);
        chk("rs_c3_wdata", csr_wr_data, 32'h0000_0088);
        chk("rs_c3_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("rs_c3_rdata", instr_read_data, 32'h0000_0008);
        chk("rs_c3_ill", {31'b0, instr_illegal}, 32'd0);
        step();
        chk("rs_c4_resp", {31'b0, instr_resp_valid}, 32'd0);
        chk("rs_c4_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("rs_c4_rdy", {31'b0, instr_req_ready}, 32'd1);

        // CSRRWI 0x340, no read, uimm 0x1F
        req(1'b0, 1'b1, 2'b01, 1'b1, 12'h340, 32'hFFFF_0000, 5'h1F);
        step();
        instr_req_valid = 1'b0;
        chk("rwi_rd", {31'b0, csr_rd_en}, 32'd0);
        chk("rwi_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("rwi_waddr", {20'b0, csr_wr_addr}, 32'h340);
        chk("rwi_wdata", csr_wr_data, 32'h0000_001F);
        chk("rwi_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("rwi_rdata", instr_read_data, 32'd0);
        step();

        // CSRRC to read-only 0xC00
        csr_rd_data = 32'h0000_1234;
        req(1'b1, 1'b1, 2'b11, 1'b0, 12'hC00, 32'hFFFF_FFFF, 5'd0);
        step();
        instr_req_valid = 1'b0;
        chk("ro_c1_rd", {31'b0, csr_rd_en}, 32'd1);
        step();
        step();
        chk("ro_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("ro_ill", {31'b0, instr_illegal}, 32'd1);
        chk("ro_rdata", instr_read_data, 32'd0);
        chk("ro_wr", {31'b0, csr_wr_en}, 32'd0);
        step();

        // Trap and instr in the same IDLE cycle
        trap_req_valid  = 1'b1;
        trap_csr_addr   = 12'h341;
        trap_write_data = 32'h8000_0004;
        req(1'b0, 1'b1, 2'b01, 1'b0, 12'h305, 32'h0000_00A5, 5'd0);
        #1;
        chk("tr_tready", {31'b0, trap_req_ready}, 32'd1);
        chk("tr_iready", {31'b0, instr_req_ready}, 32'd0);
        step();
        trap_req_valid = 1'b0;
        chk("tr_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("tr_waddr", {20'b0, csr_wr_addr}, 32'h341);
        chk("tr_wdata", csr_wr_data, 32'h8000_0004);
        chk("tr_resp", {31'b0, instr_resp_valid}, 32'd0);
        chk("tr_c1_ird", {31'b0, instr_req_ready}, 32'd0);
        step();
        chk("tr_c2_ird", {31'b0, instr_req_ready}, 32'd1);
        chk("tr_c2_wr", {31'b0, csr_wr_en}, 32'd0);
        step();
        instr_req_valid = 1'b0;
        chk("tr_c3_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("tr_c3_waddr", {20'b0, csr_wr_addr}, 32'h305);
        chk("tr_c3_wdata", csr_wr_data, 32'h0000_00A5);
        chk("tr_c3_resp", {31'b0, instr_resp_valid}, 32'd1);
        step();

        // Flush in MODIFY
        csr_rd_data = 32'h0000_0008;
        req(1'b1, 1'b1, 2'b10, 1'b0, 12'h300, 32'h1, 5'd0);
        step();
        instr_req_valid = 1'b0;
        step();
        instr_flush = 1'b1;
        step();
        instr_flush = 1'b0;
        #1;
        chk("fl_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("fl_resp", {31'b0, instr_resp_valid}, 32'd0);
        chk("fl_rdy", {31'b0, instr_req_ready}, 32'd1);
        step();
        chk("fl_c4_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("fl_c4_resp", {31'b0, instr_resp_valid}, 32'd0);

        // Flush in IDLE blocks acceptance
        instr_flush = 1'b1;
        req(1'b1, 1'b1, 2'b10, 1'b0, 12'h300, 32'h1, 5'd0);
        #1;
        chk("fli_rdy", {31'b0, instr_req_ready}, 32'd0);
        step();
        chk("fli_rd", {31'b0, csr_rd_en}, 32'd0);
        instr_flush = 1'b0;
        step();
        instr_req_valid = 1'b0;
        chk("post_rd", {31'b0, csr_rd_en}, 32'd1);
        step();
        step();
        chk("post_wdata", csr_wr_data, 32'h0000_0009);
        chk("post_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("post_rdata", instr_read_data, 32'h0000_0008);
        step();

        // Flush in WRITE is ignored
        req(1'b0, 1'b1, 2'b01, 1'b0, 12'h341, 32'h1234_5678, 5'd0);
        step();
        instr_req_valid = 1'b0;
        instr_flush = 1'b1;
        #1;
        chk("flw_wr", {31'b0, csr_wr_en}, 32'd1);
        chk("flw_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("flw_wdata", csr_wr_data, 32'h1234_5678);
        step();
        instr_flush = 1'b0;

        // Both enables off: empty response
        req(1'b0, 1'b0, 2'b00, 1'b0, 12'h300, 32'hFFFF_FFFF, 5'd0);
        step();
        instr_req_valid = 1'b0;
        chk("nop_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("nop_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("nop_ill", {31'b0, instr_illegal}, 32'd0);
        chk("nop_rdata", instr_read_data, 32'd0);
        step();

        // Reset in READ abandons the access
        req(1'b1, 1'b1, 2'b01, 1'b0, 12'h300, 32'h5, 5'd0);
        step();
        instr_req_valid = 1'b0;
        chk("rr_rd", {31'b0, csr_rd_en}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rr_rd0", {31'b0, csr_rd_en}, 32'd0);
        chk("rr_wr0", {31'b0, csr_wr_en}, 32'd0);
        chk("rr_resp0", {31'b0, instr_resp_valid}, 32'd0);
        chk("rr_rdata0", instr_read_data, 32'd0);
        step();
        chk("rr_wr1", {31'b0, csr_wr_en}, 32'd0);
        chk("rr_resp1", {31'b0, instr_resp_valid}, 32'd0);
        chk("rr_rdy", {31'b0, instr_req_ready}, 32'd1);

        // Unimplemented CSR reported by the file
        csr_rd_data    = 32'h0000_DEAD;
        csr_rd_invalid = 1'b1;
        req(1'b1, 1'b1, 2'b01, 1'b0, 12'h7C0, 32'h55, 5'd0);
        step();
        instr_req_valid = 1'b0;
        step();
        step();
        csr_rd_invalid = 1'b0;
        chk("inv_resp", {31'b0, instr_resp_valid}, 32'd1);
        chk("inv_ill", {31'b0, instr_illegal}, 32'd1);
        chk("inv_wr", {31'b0, csr_wr_en}, 32'd0);
        chk("inv_rdata", instr_read_data, 32'd0);
        step();
        chk("inv_idle", {31'b0, instr_resp_valid}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
